// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared constants and state encoding for the SPI flash read sequencer
package spi_flash_pkg;

    localparam int         ADDR_W       = 24;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [7:0] READ_OPCODE  = OP_FAST_READ;
`else
    localparam logic [7:0] READ_OPCODE  = OP_READ;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_DESEL
    } state_t;

endpackage

// File: rtl/spi_flash_shifter.sv
// rtl/spi_flash_shifter.sv - SCLK divider plus 8-bit mode-0 shift engine, one byte per start
module spi_flash_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       hold,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       sclk,
    output logic       mosi
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [2:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       tx_sh;
    logic [7:0]       rx_sh;
    logic             tick;

    assign tick      = active && (div_cnt == DIV_LAST);
    // Asserted in the cycle whose closing edge drops SCLK after the 8th sample,
    // so a start in the same cycle continues without a gap.
    assign byte_done = tick && sclk && (bit_cnt == 3'd7);
    assign rx_byte   = rx_sh;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            bit_cnt <= 3'd0;
            div_cnt <= '0;
            tx_sh   <= 8'd0;
            rx_sh   <= 8'd0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (hold) begin
            active  <= 1'b0;
            bit_cnt <= 3'd0;
            div_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
        end else if (start && (!active || byte_done)) begin
            active  <= 1'b1;
            bit_cnt <= 3'd0;
            div_cnt <= '0;
            tx_sh   <= tx_byte;
            sclk    <= 1'b0;
            mosi    <= tx_byte[7];
        end else if (active) begin
            if (tick) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk  <= 1'b1;
                    rx_sh <= {rx_sh[6:0], miso};
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == 3'd7) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        mosi    <= tx_sh[6];
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_flash_read_ctrl.sv
// rtl/spi_flash_read_ctrl.sv - SPI NOR READ burst sequencer; SPI_FLASH_FAST_READ_EN selects 0x0B with dummy byte
module spi_flash_read_ctrl
    import spi_flash_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16,
    parameter int CS_IDLE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [23:0]       req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              abort,
    output logic [7:0]        data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic              flash_cs,
    output logic              flash_sclk,
    output logic              flash_mosi,
    input  logic              flash_miso
);

    localparam int DS_W = $clog2(CS_IDLE) + 1;

    state_t            state;
    state_t            nstate;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_cnt;
    logic [1:0]        byte_idx;
    logic [DS_W-1:0]   desel_cnt;
    logic              pend;

    logic              sh_start;
    logic              sh_hold;
    logic [7:0]        sh_tx;
    logic [7:0]        sh_rx;
    logic              sh_done;

    logic              accept;
    logic              abort_hit;
    logic              can_out;
    logic              last_byte;
    logic              deliver;

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign abort_hit = abort && (state != ST_IDLE);
    assign can_out   = !data_valid || data_ready;
    assign last_byte = (len_cnt == LEN_W'(1));
    // pend marks a finished byte parked in the shifter while SCLK is stalled
    assign deliver   = (state == ST_DATA) && (sh_done || pend) && can_out && !abort_hit;

    spi_flash_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .reset     (reset),
        .start     (sh_start),
        .hold      (sh_hold),
        .tx_byte   (sh_tx),
        .miso      (flash_miso),
        .rx_byte   (sh_rx),
        .byte_done (sh_done),
        .sclk      (flash_sclk),
        .mosi      (flash_mosi)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            ST_IDLE:  if (req_valid && (req_len != '0)) nstate = ST_CMD;
            ST_CMD:   if (sh_done) nstate = ST_ADDR;
            ST_ADDR: begin
                if (sh_done && (byte_idx == 2'd2)) begin
`ifdef SPI_FLASH_FAST_READ_EN
                    nstate = ST_DUMMY;
`else
                    nstate = ST_DATA;
`endif
                end
            end
`ifdef SPI_FLASH_FAST_READ_EN
            ST_DUMMY: if (sh_done) nstate = ST_DATA;
`endif
            ST_DATA:  if (deliver && last_byte) nstate = ST_DESEL;
            ST_DESEL: if (desel_cnt == DS_W'(CS_IDLE - 1)) nstate = ST_IDLE;
            default:  nstate = ST_IDLE;
        endcase
        if (abort_hit && (state != ST_DESEL)) nstate = ST_DESEL;
    end

    always_comb begin
        sh_start = 1'b0;
        sh_tx    = 8'd0;
        sh_hold  = abort_hit;
        case (state)
            ST_IDLE: begin
                sh_start = req_valid && (req_len != '0);
                sh_tx    = READ_OPCODE;
            end
            ST_CMD: begin
                sh_start = sh_done;
                sh_tx    = addr_q[23:16];
            end
            ST_ADDR: begin
                sh_start = sh_done;
                case (byte_idx)
                    2'd0:    sh_tx = addr_q[15:8];
                    2'd1:    sh_tx = addr_q[7:0];
                    default: sh_tx = 8'd0;
                endcase
            end
`ifdef SPI_FLASH_FAST_READ_EN
            ST_DUMMY: sh_start = sh_done;
`endif
            ST_DATA:  sh_start = deliver && !last_byte;
            default: begin
                sh_start = 1'b0;
                sh_tx    = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            len_cnt    <= '0;
            byte_idx   <= 2'd0;
            desel_cnt  <= '0;
            pend       <= 1'b0;
            data_out   <= 8'd0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            flash_cs   <= 1'b1;
        end else begin
            done     <= 1'b0;
            flash_cs <= (nstate == ST_IDLE) || (nstate == ST_DESEL);

            if (accept) begin
                addr_q   <= req_addr;
                len_cnt  <= req_len;
                byte_idx <= 2'd0;
                if (req_len == '0) done <= 1'b1;
            end

            if ((state == ST_DESEL) && (nstate == ST_IDLE)) done <= 1'b1;

            if ((state == ST_ADDR) && sh_done) byte_idx <= byte_idx + 2'd1;

            if (state == ST_DESEL) begin
                desel_cnt <= desel_cnt + DS_W'(1);
            end else begin
                desel_cnt <= '0;
            end

            if (abort_hit) begin
                data_valid <= 1'b0;
                pend       <= 1'b0;
            end else begin
                if (data_valid && data_ready) data_valid <= 1'b0;
                if (deliver) begin
                    data_out   <= sh_rx;
                    data_valid <= 1'b1;
                    pend       <= 1'b0;
                    len_cnt    <= len_cnt - LEN_W'(1);
                end else if ((state == ST_DATA) && sh_done) begin
                    pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// tb/tb_spi_flash_read_ctrl.sv - directed bench with a behavioural SPI NOR model
module tb_spi_flash_read_ctrl;

    localparam int CLK_DIV = 2;
    localparam int LEN_W   = 16;
    localparam int CS_IDLE = 4;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam int         HDR    = 40;
    localparam logic [7:0] EXP_OP = 8'h0B;
`else
    localparam int         HDR    = 32;
    localparam logic [7:0] EXP_OP = 8'h03;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [23:0]      req_addr = 24'd0;
    logic [LEN_W-1:0] req_len = '0;
    logic             abort = 1'b0;
    logic [7:0]       data_out;
    logic             data_valid;
    logic             data_ready = 1'b1;
    logic             busy;
    logic             done;
    logic             flash_cs;
    logic             flash_sclk;
    logic             flash_mosi;
    logic             flash_miso = 1'b0;

    always #5 clk = ~clk;

    spi_flash_read_ctrl #(
        .CLK_DIV (CLK_DIV),
        .LEN_W   (LEN_W),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .abort      (abort),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .busy       (busy),
        .done       (done),
        .flash_cs   (flash_cs),
        .flash_sclk (flash_sclk),
        .flash_mosi (flash_mosi),
        .flash_miso (flash_miso)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:1023];
    int          fl_bits = 0;
    logic [31:0] fl_hdr = 32'd0;
    logic        fl_dummy_or = 1'b0;
    int          fl_k;
    logic [9:0]  fl_a;
    logic [7:0]  fl_byte;
    int          rise_cnt = 0;

    always @(posedge flash_sclk) rise_cnt++;

    always @(posedge flash_sclk or negedge flash_cs) begin
        if (flash_sclk && !flash_cs) begin
            if (fl_bits < 32) fl_hdr = {fl_hdr[30:0], flash_mosi};
            else if (fl_bits < HDR) fl_dummy_or = fl_dummy_or | flash_mosi;
            fl_bits++;
        end else if (!flash_sclk) begin
            fl_bits     = 0;
            fl_dummy_or = 1'b0;
        end
    end

    always @(negedge flash_sclk) begin
        if (!flash_cs && fl_bits >= HDR) begin
            fl_k       = fl_bits - HDR;
            fl_a       = fl_hdr[9:0] + 10'(fl_k / 8);
            fl_byte    = mem[fl_a];
            flash_miso = fl_byte[7 - (fl_k % 8)];
        end
    end

    logic [7:0] rxq[$];
    int         done_cnt = 0;
    int         cs_fall_cnt = 0;
    logic       prev_cs = 1'b1;

    always @(negedge clk) begin
        if (data_valid && data_ready) rxq.push_back(data_out);
        if (done) done_cnt++;
        if (prev_cs && !flash_cs) cs_fall_cnt++;
        prev_cs = flash_cs;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [23:0] a, input logic [LEN_W-1:0] l);
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = l;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound, output int n);
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_bytes(input string tag, input int base, input int n, input logic [31:0] exp_word);
        logic [31:0] obs;
        for (int i = 0; i < n; i++) begin
            obs = (base + i < rxq.size()) ? {24'd0, rxq[base + i]} : 32'hDEAD;
            chk(tag, obs, {24'd0, exp_word[8*(n-1-i) +: 8]});
        end
    endtask

    int n;
    int base_r;
    int base_q;
    int base_d;
    int base_c;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[256] = 8'hA5;
        mem[257] = 8'h5A;
        mem[258] = 8'h01;
        mem[259] = 8'hFF;

        #1 reset = 1'b1;
        #1;
        chk("rst_cs",    {31'd0, flash_cs},   32'd1);
        chk("rst_sclk",  {31'd0, flash_sclk}, 32'd0);
        chk("rst_mosi",  {31'd0, flash_mosi}, 32'd0);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_data",  {24'd0, data_out},   32'd0);
        chk("rst_busy",  {31'd0, busy},       32'd0);
        chk("rst_done",  {31'd0, done},       32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_ready", {31'd0, req_ready}, 32'd1);

        // Plain burst with the consumer always ready
        base_r = rise_cnt;
        base_q = rxq.size();
        base_d = done_cnt;
        send_req(24'h000100, 16'd4);
        chk("t1_cs_fall", {31'd0, flash_cs},  32'd0);
        chk("t1_busy",    {31'd0, busy},      32'd1);
        chk("t1_ready",   {31'd0, req_ready}, 32'd0);
        n = 0;
        while (flash_sclk !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("t1_first_rise", n, CLK_DIV);
        wait_done("t1_done", 3000, n);
        tick();
        tick();
        chk("t1_hdr", fl_hdr, {EXP_OP, 24'h000100});
`ifdef SPI_FLASH_FAST_READ_EN
        chk("t1_dummy_mosi", {31'd0, fl_dummy_or}, 32'd0);
`endif
        chk("t1_rises", rise_cnt - base_r, HDR + 32);
        chk("t1_nbytes", rxq.size() - base_q, 4);
        chk_bytes("t1_byte", base_q, 4, 32'hA55A01FF);
        chk("t1_done_pulses", done_cnt - base_d, 1);

        // Consumer stalls with the first byte pending
        data_ready = 1'b0;
        base_r = rise_cnt;
        base_q = rxq.size();
        send_req(24'h000100, 16'd4);
        n = 0;
        while (data_valid !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk("t2_first_valid", {31'd0, data_valid}, 32'd1);
        repeat (40) tick();
        chk("t2_hold_valid", {31'd0, data_valid}, 32'd1);
        chk("t2_hold_data",  {24'd0, data_out},   32'hA5);
        chk("t2_stall_sclk", {31'd0, flash_sclk}, 32'd0);
        chk("t2_stall_cs",   {31'd0, flash_cs},   32'd0);
        chk("t2_stall_rises", rise_cnt - base_r, HDR + 16);
        data_ready = 1'b1;
        wait_done("t2_done", 3000, n);
        tick();
        tick();
        chk("t2_rises", rise_cnt - base_r, HDR + 32);
        chk_bytes("t2_byte", base_q, 4, 32'hA55A01FF);

        // Zero-length request
        base_c = cs_fall_cnt;
        base_d = done_cnt;
        send_req(24'h000100, 16'd0);
        chk("t3_done",  {31'd0, done},      32'd1);
        chk("t3_ready", {31'd0, req_ready}, 32'd1);
        chk("t3_busy",  {31'd0, busy},      32'd0);
        tick();
        chk("t3_done_clear", {31'd0, done}, 32'd0);
        repeat (5) tick();
        chk("t3_no_cs", cs_fall_cnt - base_c, 0);
        chk("t3_done_pulses", done_cnt - base_d, 1);

        // Abort while the second byte is on data_out
        base_q = rxq.size();
        send_req(24'h000100, 16'd16);
        n = 0;
        while (!(data_valid === 1'b1 && rxq.size() - base_q == 1) && n < 3000) begin
            tick();
            n++;
        end
        chk("t4_second_byte", {24'd0, data_out}, 32'h5A);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_cs",    {31'd0, flash_cs},   32'd1);
        chk("t4_sclk",  {31'd0, flash_sclk}, 32'd0);
        chk("t4_valid", {31'd0, data_valid}, 32'd0);
        base_r = rise_cnt;
        wait_done("t4_done", 50, n);
        chk("t4_done_lat", n, CS_IDLE);
        tick();
        tick();
        chk("t4_nbytes", rxq.size() - base_q, 2);
        chk_bytes("t4_byte", base_q, 2, 32'h0000A55A);
        chk("t4_no_rises", rise_cnt - base_r, 0);

        // Reset in the middle of the address phase
        base_r = rise_cnt;
        send_req(24'h000100, 16'd4);
        n = 0;
        while (rise_cnt - base_r < 12 && n < 500) begin
            tick();
            n++;
        end
        reset = 1'b1;
        #1;
        chk("t5_cs",    {31'd0, flash_cs},   32'd1);
        chk("t5_sclk",  {31'd0, flash_sclk}, 32'd0);
        chk("t5_mosi",  {31'd0, flash_mosi}, 32'd0);
        chk("t5_busy",  {31'd0, busy},       32'd0);
        chk("t5_valid", {31'd0, data_valid}, 32'd0);
        chk("t5_data",  {24'd0, data_out},   32'd0);
        chk("t5_done",  {31'd0, done},       32'd0);
        tick();
        reset = 1'b0;
        tick();
        base_q = rxq.size();
        send_req(24'h000102, 16'd2);
        wait_done("t5_done_after", 3000, n);
        tick();
        tick();
        chk("t5_nbytes", rxq.size() - base_q, 2);
        chk_bytes("t5_byte", base_q, 2, 32'h000001FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
